// File: rtl/car_lane.sv
// car_lane: one lane of cars scrolling across a frog-crossing playfield.
//
// Purpose
//   On a Load pulse the lane configuration is captured and the cars are
//   placed on a circular track one per frame. The lane then moves every
//   valid car by a sub-pixel speed each frame (while not paused).
//   Track coordinates run 0..TRACK_LEN-1 and screen X = track - CAR_W, so a
//   car can slide fully off either edge of the screen before it wraps.
//
// Ports
//   frame_clk    in   one rising edge per video frame (sole clock)
//   Reset_n      in   asynchronous active-low reset
//   Load         in   single-cycle pulse: capture config, start placement
//   Number_Cars  in   active car count minus 1
//   Gap_Size     in   pixel gap between adjacent cars
//   Speed        in   quarter-pixels per frame
//   Direction    in   1 = rightward (track increases), 0 = leftward
//   Pause        in   level, freezes motion while high
//   Frog_X       in   frog left edge, screen coordinates
//   Car_T        out  per-car left edge, track coordinates
//   Car_Valid    out  per-car active flag
//   Load_Done    out  one-cycle pulse on the cycle the lane enters RUN
//   Frog_Hit     out  registered overlap of the frog with any valid car
//
// Handshake: Load has no ready. Any Load (in any state) restarts placement
// on the next edge and wins over Pause; no other input changes the latched
// configuration.
module car_lane #(
    parameter int NUM_CARS = 4,
    parameter int SCREEN_W = 640,
    parameter int CAR_W    = 64,
    parameter int FROG_W   = 32,
    parameter int X_W      = 11,
    parameter int NC_W     = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
    input  logic                               frame_clk,
    input  logic                               Reset_n,
    input  logic                               Load,
    input  logic [NC_W-1:0]                    Number_Cars,
    input  logic [7:0]                         Gap_Size,
    input  logic [4:0]                         Speed,
    input  logic                               Direction,
    input  logic                               Pause,
    input  logic [X_W-1:0]                     Frog_X,
    output logic [NUM_CARS-1:0][X_W-1:0]       Car_T,
    output logic [NUM_CARS-1:0]                Car_Valid,
    output logic                               Load_Done,
    output logic                               Frog_Hit
);

    localparam int TRACK_LEN = SCREEN_W + CAR_W;
    localparam logic [X_W:0] TRACK_X = (X_W+1)'(TRACK_LEN);
    localparam logic [X_W:0] CAR_X   = (X_W+1)'(CAR_W);
    localparam logic [X_W:0] FROG_XW = (X_W+1)'(FROG_W);

    typedef enum logic [1:0] {IDLE, PLACE, RUN, HOLD} state_t;
    state_t state, state_nxt;

    // latched configuration
    logic [NC_W-1:0] num_r;
    logic [7:0]      gap_r;
    logic [4:0]      speed_r;
    logic            dir_r;

    logic [1:0]      frac;
    logic [NC_W-1:0] place_idx;
    logic [X_W-1:0]  place_pos;   // track position of the car placed next

    // ---------------- FSM ----------------
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            PLACE:   if (place_idx == num_r) state_nxt = RUN;
            RUN:     if (Pause)  state_nxt = HOLD;
            HOLD:    if (!Pause) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (Load) state_nxt = PLACE;
    end

    // ---------------- datapath combinational ----------------
    logic [5:0]     sum;
    logic [X_W:0]   step_ext;
    logic           move_en;
    logic [X_W:0]   stride, pos_sum;
    logic [X_W-1:0] pos_nxt;
    logic [X_W:0]   frog_f, t_ext, r_sum;
    logic [X_W-1:0] moved_t [NUM_CARS];
    logic [NUM_CARS-1:0] overlap;

    always_comb begin
        sum      = {4'd0, frac} + {1'b0, speed_r};
        step_ext = (X_W+1)'(sum[5:2]);
        // Pause freezes the frame it is seen, even before the FSM reaches HOLD.
        move_en  = (state == RUN) && !Pause && !Load;

        // CAR_W + 255 is well below TRACK_LEN, so one conditional subtract
        // keeps the running placement position reduced mod TRACK_LEN.
        stride   = CAR_X + (X_W+1)'(gap_r);
        pos_sum  = {1'b0, place_pos} + stride;
        pos_nxt  = (pos_sum >= TRACK_X) ? X_W'(pos_sum - TRACK_X) : X_W'(pos_sum);

        // Frog converted to track coordinates.
        frog_f   = (X_W+1)'(Frog_X) + CAR_X;

        t_ext    = '0;
        r_sum    = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            t_ext = {1'b0, Car_T[i]};
            if (dir_r) begin
                r_sum = t_ext + step_ext;
                moved_t[i] = (r_sum >= TRACK_X) ? X_W'(r_sum - TRACK_X) : X_W'(r_sum);
            end else begin
                r_sum = (t_ext < step_ext) ? (t_ext + TRACK_X - step_ext) : (t_ext - step_ext);
                moved_t[i] = X_W'(r_sum);
            end
            overlap[i] = Car_Valid[i] && (frog_f < t_ext + CAR_X) && (t_ext < frog_f + FROG_XW);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Car_T     <= '0;
            Car_Valid <= '0;
            Load_Done <= 1'b0;
            Frog_Hit  <= 1'b0;
            num_r     <= '0;
            gap_r     <= '0;
            speed_r   <= '0;
            dir_r     <= 1'b0;
            frac      <= '0;
            place_idx <= '0;
            place_pos <= '0;
        end else begin
            Load_Done <= (state == PLACE) && (state_nxt == RUN);
            // Evaluated on the positions before this frame's move.
            Frog_Hit  <= ((state == RUN) || (state == HOLD)) && !Load && (|overlap);

            if (Load) begin
                num_r     <= Number_Cars;
                gap_r     <= Gap_Size;
                speed_r   <= Speed;
                dir_r     <= Direction;
                frac      <= '0;
                place_idx <= '0;
                place_pos <= '0;
            end else if (state == PLACE) begin
                if (place_idx == '0) begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        if (i > int'(num_r)) begin
                            Car_T[i]     <= '0;
                            Car_Valid[i] <= 1'b0;
                        end
                    end
                end
                Car_T[place_idx]     <= place_pos;
                Car_Valid[place_idx] <= 1'b1;
                place_idx            <= place_idx + 1'b1;
                place_pos            <= pos_nxt;
            end else if (move_en) begin
                frac <= sum[1:0];
                for (int i = 0; i < NUM_CARS; i++) begin
                    if (Car_Valid[i]) Car_T[i] <= moved_t[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_car_lane.sv
module tb_car_lane;
  localparam int NUM_CARS = 4;
  localparam int SCREEN_W = 640;
  localparam int CAR_W    = 64;
  localparam int FROG_W   = 32;
  localparam int X_W      = 11;
  localparam int NC_W     = 2;
  localparam int TRACK    = SCREEN_W + CAR_W;

  // ---------------- clock / reset ----------------
  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic                         Reset_n;
  logic                         Load;
  logic [NC_W-1:0]              Number_Cars;
  logic [7:0]                   Gap_Size;
  logic [4:0]                   Speed;
  logic                         Direction;
  logic                         Pause;
  logic [X_W-1:0]               Frog_X;
  logic [NUM_CARS-1:0][X_W-1:0] Car_T;
  logic [NUM_CARS-1:0]          Car_Valid;
  logic                         Load_Done;
  logic                         Frog_Hit;

  car_lane #(
    .NUM_CARS(NUM_CARS), .SCREEN_W(SCREEN_W), .CAR_W(CAR_W),
    .FROG_W(FROG_W), .X_W(X_W)
  ) dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .Load(Load),
    .Number_Cars(Number_Cars), .Gap_Size(Gap_Size), .Speed(Speed),
    .Direction(Direction), .Pause(Pause), .Frog_X(Frog_X),
    .Car_T(Car_T), .Car_Valid(Car_Valid), .Load_Done(Load_Done),
    .Frog_Hit(Frog_Hit)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Lane is described by where each car was placed plus the total distance
  // travelled in quarter pixels since placement finished.
  int m_mode;            // 0 idle, 1 placing, 2 running (moving or held)
  int m_num, m_gap, m_speed, m_dir;
  int m_cnt;
  int m_acc;
  bit m_held;            // previous running frame saw Pause high
  int base [NUM_CARS];
  int et   [NUM_CARS];
  bit ev   [NUM_CARS];
  bit e_done, e_hit;

  logic [X_W-1:0] exp_q[$];

  function automatic int wrap(int x);
    return ((x % TRACK) + TRACK) % TRACK;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_num = 0; m_gap = 0; m_speed = 0; m_dir = 0;
    m_cnt = 0; m_acc = 0; m_held = 0; e_done = 0; e_hit = 0;
    for (int i = 0; i < NUM_CARS; i++) begin
      base[i] = 0; et[i] = 0; ev[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit hit;
    int f;
    hit = 0;
    f = int'(Frog_X) + CAR_W;
    for (int i = 0; i < NUM_CARS; i++)
      if (ev[i] && (f < et[i] + CAR_W) && (et[i] < f + FROG_W)) hit = 1;
    e_hit  = (m_mode == 2) && !Load && hit;
    e_done = 0;
    if (Load) begin
      m_num = int'(Number_Cars); m_gap = int'(Gap_Size);
      m_speed = int'(Speed); m_dir = int'(Direction);
      m_mode = 1; m_cnt = 0; m_acc = 0;
    end else if (m_mode == 1) begin
      if (m_cnt == 0)
        for (int i = 0; i < NUM_CARS; i++)
          if (i > m_num) begin ev[i] = 0; et[i] = 0; end
      base[m_cnt] = (m_cnt * (CAR_W + m_gap)) % TRACK;
      et[m_cnt] = base[m_cnt];
      ev[m_cnt] = 1;
      m_cnt++;
      if (m_cnt > m_num) begin m_mode = 2; e_done = 1; m_held = 0; end
    end else if (m_mode == 2) begin
      if (!Pause && !m_held) begin
        m_acc += m_speed;
        for (int i = 0; i < NUM_CARS; i++)
          if (ev[i]) et[i] = wrap(base[i] + (m_dir ? 1 : -1) * (m_acc / 4));
      end
      m_held = Pause;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    logic [X_W-1:0] e;
    logic [NUM_CARS-1:0] evv;
    for (int i = 0; i < NUM_CARS; i++) exp_q.push_back(X_W'(et[i]));
    for (int i = 0; i < NUM_CARS; i++) begin
      e = exp_q.pop_front();
      checks++;
      assert (Car_T[i] === e) else begin
        errors++;
        $error("FAIL %s car_t[%0d] got %0d exp %0d", tag, i, Car_T[i], e);
      end
      evv[i] = ev[i];
    end
    checks++;
    assert (Car_Valid === evv) else begin
      errors++;
      $error("FAIL %s car_valid got %b exp %b", tag, Car_Valid, evv);
    end
    checks++;
    assert (Load_Done === e_done) else begin
      errors++;
      $error("FAIL %s load_done got %b exp %b", tag, Load_Done, e_done);
    end
    checks++;
    assert (Frog_Hit === e_hit) else begin
      errors++;
      $error("FAIL %s frog_hit got %b exp %b", tag, Frog_Hit, e_hit);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(string tag);
    @(posedge frame_clk);
    #1;
    model_edge();
    check_outputs(tag);
  endtask

  task automatic do_load(int num, int gap, int spd, int dir);
    Number_Cars = NC_W'(num); Gap_Size = 8'(gap);
    Speed = 5'(spd); Direction = dir[0];
    Load = 1'b1;
    tick("load");
    Load = 1'b0;
    // Junk on the config inputs must be ignored from here on.
    Number_Cars = NC_W'($urandom_range(0, 3)); Gap_Size = 8'($urandom_range(0, 255));
    Speed = 5'($urandom_range(0, 31)); Direction = 1'($urandom_range(0, 1));
  endtask

  task automatic run(int n, string tag);
    for (int k = 0; k < n; k++) begin
      Frog_X = X_W'($urandom_range(0, SCREEN_W - FROG_W));
      tick(tag);
    end
  endtask

  task automatic async_reset(string tag);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    #1;
    Reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0; Load = 1'b0; Number_Cars = '0; Gap_Size = '0;
    Speed = '0; Direction = 1'b0; Pause = 1'b0; Frog_X = '0;
    model_reset();
    #11;
    check_outputs("reset");
    #1;
    Reset_n = 1'b1;
    run(3, "idle");

    // two cars, gap 40, speed 5 rightward
    do_load(1, 40, 5, 1);
    tick("place0");
    check_val("done_early", 32'(Load_Done), 0);
    tick("place1");
    check_val("done_pulse", 32'(Load_Done), 1);
    check_val("car1_pos", 32'(Car_T[1]), 104);
    check_val("valid_0011", 32'(Car_Valid), 32'h3);
    Frog_X = X_W'(600);
    tick("run1"); tick("run2"); tick("run3"); tick("run4");
    check_val("car0_after4", 32'(Car_T[0]), 5);
    check_val("car1_after4", 32'(Car_T[1]), 109);

    // pause for three frames, then resume
    Pause = 1'b1;
    run(3, "paused");
    Pause = 1'b0;
    run(4, "resume");

    // frog hit: single car driven to T=100 at 5 px per frame
    do_load(0, 0, 20, 1);
    tick("hit_place");
    Frog_X = X_W'(600);
    for (int k = 0; k < 20; k++) tick("hit_drive");
    check_val("car_at_100", 32'(Car_T[0]), 100);
    Pause = 1'b1;
    Frog_X = X_W'(60);
    tick("hit_on");
    check_val("hit_on", 32'(Frog_Hit), 1);
    Frog_X = X_W'(101);
    tick("hit_off");
    check_val("hit_off", 32'(Frog_Hit), 0);
    Pause = 1'b0;

    // leftward wrap from 0 by 4
    do_load(0, 0, 16, 0);
    tick("left_place");
    tick("left_wrap");
    check_val("left_wrap", 32'(Car_T[0]), 700);
    run(200, "left_long");

    // load and pause together: load wins
    Pause = 1'b1;
    do_load(2, 100, 31, 1);
    Pause = 1'b0;
    run(250, "right_fast");

    // reset in the middle of placement
    do_load(3, 10, 7, 1);
    tick("mid_place");
    async_reset("reset_mid_place");
    run(4, "after_reset");
    do_load(3, 10, 7, 1);
    run(4, "reload");
    check_val("valid_1111", 32'(Car_Valid), 32'hf);
    run(20, "reload_run");

    // reset in the middle of running
    async_reset("reset_mid_run");
    run(3, "after_reset2");

    // randomized lanes with random pauses and stray loads
    for (int r = 0; r < 6; r++) begin
      do_load($urandom_range(0, 3), $urandom_range(0, 255),
              $urandom_range(0, 31), $urandom_range(0, 1));
      for (int k = 0; k < 150; k++) begin
        Pause  = ($urandom_range(0, 7) == 0);
        Frog_X = X_W'($urandom_range(0, SCREEN_W - FROG_W));
        if ($urandom_range(0, 59) == 0) begin
          Number_Cars = NC_W'($urandom_range(0, 3));
          Gap_Size = 8'($urandom_range(0, 255));
          Speed = 5'($urandom_range(0, 31));
          Direction = 1'($urandom_range(0, 1));
          Load = 1'b1;
        end else begin
          Speed = 5'($urandom_range(0, 31));
          Load = 1'b0;
        end
        tick("random");
        Load = 1'b0;
      end
      Pause = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
